riscv_data_mem: RTL and testbench

Data-side memory subsystem attached to the core's data port, consumed in the MEM stage. It provides word-organised RAM with combinational read and synchronous write, plus a small memory-mapped I/O window containing a free-running cycle counter and a byte-wide console transmit FIFO with a valid/ready drain interface. The core reads `data_o` combinationally in the same cycle it presents the address, both for forwarding and for write-back, so the read path has no register.

---
 rtl/riscv_data_mem_pkg.sv | 53 +++++
 rtl/riscv_console_fifo.sv | 70 +++++++
 rtl/riscv_data_mem.sv | 154 +++++++++++++++
 tb/tb_riscv_data_mem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_data_mem_pkg.sv
// Shared constants and types for the riscv_data_mem data-side memory subsystem.
//   - MMIO window base and register word offsets (TXDATA / STATUS / CYCLE)
//   - STATUS register bit positions
//   - access-target enum and the address decode helper
// Build option: RISCV_DMEM_CONSOLE_EN (used by riscv_data_mem) enables the console FIFO.
package riscv_data_mem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Word offsets (addr[15:2]) inside the MMIO window.
    localparam logic [13:0] OFF_TXDATA = 14'h0;
    localparam logic [13:0] OFF_STATUS = 14'h1;
    localparam logic [13:0] OFF_CYCLE  = 14'h2;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_CNT_LSB   = 8;
    localparam int unsigned STATUS_CNT_W     = 8;

    // STATUS value when no console is built: empty only.
    localparam logic [31:0] STATUS_NO_CONSOLE = 32'h0000_0002;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelTxdata,
        SelStatus,
        SelCycle
    } dmem_sel_e;

    // Resolve which storage element an access targets. Inactive accesses and
    // unmapped MMIO offsets resolve to SelNone (reads 0, writes ignored).
    function automatic dmem_sel_e decode_sel(input logic ce, input logic [31:0] addr,
                                             input logic [15:0] base_hi);
        dmem_sel_e sel;
        sel = SelNone;
        if (ce) begin
            if (addr[31:16] != base_hi) begin
                sel = SelRam;
            end else begin
                case (addr[15:2])
                    OFF_TXDATA: sel = SelTxdata;
                    OFF_STATUS: sel = SelStatus;
                    OFF_CYCLE:  sel = SelCycle;
                    default:    sel = SelNone;
                endcase
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/riscv_console_fifo.sv
// Synchronous FIFO used as the console transmit queue.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   enqueue wdata (caller guarantees not full unless popping)
//   pop           dequeue head (caller guarantees not empty)
//   head          current head entry; reads 0 while empty
//   full, empty   occupancy flags derived from count
//   count         number of stored entries (0..DEPTH)
module riscv_console_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;

    // Storage is not reset; reset only empties the queue.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers are log2(DEPTH) wide and wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign full  = (count_q == (PW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem[rptr_q];

endmodule

// File: rtl/riscv_data_mem.sv
// Data-side memory for the core's MEM stage: word RAM with combinational read and
// synchronous write, plus an MMIO window (TXDATA, STATUS, CYCLE).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ce_i, we_i          access enable and write enable (write qualified by ce_i)
//   addr_i              byte address, bits [1:0] ignored
//   data_i / data_o     write data / combinational read data (0 when ce_i low)
//   tx_valid_o          console byte available
//   tx_data_o           console FIFO head
//   tx_ready_i          console sink accepts the byte
// Build option: define RISCV_DMEM_CONSOLE_EN to build the console FIFO and overflow
// flag; otherwise TXDATA writes are dropped, STATUS reads "empty" and tx ports are tied 0.
module riscv_data_mem
    import riscv_data_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_sel_e     sel;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram[DEPTH];
    logic [31:0]   cycle_q;
    logic [31:0]   cycle_d;
    logic [31:0]   status;
    logic          unused_addr_lsb;

    assign sel     = decode_sel(ce_i, addr_i, MMIO_BASE[31:16]);
    // Bits above the index are dropped, so the RAM aliases modulo DEPTH.
    assign ram_idx = addr_i[AW+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    // ---------------------------------------------------------------- RAM
    always_ff @(posedge clk) begin
        if (sel == SelRam && we_i) begin
            ram[ram_idx] <= data_i;
        end
    end

    // ---------------------------------------------------------------- cycle counter
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (sel == SelCycle && we_i) begin
            cycle_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    // ---------------------------------------------------------------- console
`ifdef RISCV_DMEM_CONSOLE_EN
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          push_req;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          ovf_q;
    logic          ovf_d;

    assign push_req  = (sel == SelTxdata) && we_i;
    assign fifo_pop  = !fifo_empty && tx_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign fifo_push = push_req && (!fifo_full || fifo_pop);

    riscv_console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (data_i[7:0]),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Set after clear so a dropped push wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (sel == SelStatus && we_i && data_i[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        status = '0;
        status[STATUS_FULL_BIT]  = fifo_full;
        status[STATUS_EMPTY_BIT] = fifo_empty;
        status[STATUS_OVF_BIT]   = ovf_q;
        status[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
    end

    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_head;
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready_i;
    assign status          = STATUS_NO_CONSOLE;
    assign tx_valid_o      = 1'b0;
    assign tx_data_o       = 8'h00;
`endif

    // ---------------------------------------------------------------- read mux
    // Combinational: the core consumes data_o in the same cycle it drives addr_i.
    always_comb begin
        data_o = '0;
        case (sel)
            SelRam:    data_o = ram[ram_idx];
            SelStatus: data_o = status;
            SelCycle:  data_o = cycle_q;
            default:   data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_data_mem.sv
module tb_riscv_data_mem;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CY = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    riscv_data_mem #(
        .DEPTH      (1024),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive after the edge, sample data_o at the falling edge.
    task automatic access(input logic ce, input logic we, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
        ce_i   = ce;
        we_i   = we;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        rd = data_o;
        @(posedge clk);
        #1;
        ce_i = 1'b0;
        we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        access(1'b1, 1'b1, a, d, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        access(1'b1, 1'b0, a, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) access(1'b0, 1'b0, 32'h0, 32'h0, rd);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic accept);
        if (accept) exp_q.push_back(b);
        wr(A_TX, {24'h0, b});
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ce_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every completed handshake must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && tx_valid_o && tx_ready_i) begin
            if (exp_q.size() == 0) check("tx_spurious", {31'h0, tx_valid_o}, 32'h0);
            else check("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        rd_chk("rst_cycle", A_CY, 32'h0);
        rd_chk("rst_status", A_ST, 32'h0000_0002);

        // RAM, aliasing and decode
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd);
        check("ce_low_rd", rd, 32'h0);
        wr(32'h8000_0FFF, 32'h1234_5678);
        rd_chk("ram_top_word", 32'h0000_0FFC, 32'h1234_5678);
        rd_chk("mmio_unmapped", BASE + 32'hC, 32'h0);
        rd_chk("txdata_rd", A_TX, 32'h0);

        // Cycle counter load and wrap
        wr(A_CY, 32'hFFFF_FFFE);
        rd_chk("cyc_load", A_CY, 32'hFFFF_FFFE);
        rd_chk("cyc_max", A_CY, 32'hFFFF_FFFF);
        rd_chk("cyc_wrap", A_CY, 32'h0000_0000);
        rd_chk("cyc_inc", A_CY, 32'h0000_0001);

`ifdef RISCV_DMEM_CONSOLE_EN
        // Push three bytes with the sink stalled, then drain
        tx_ready_i = 1'b0;
        check("pre_push_valid", {31'h0, tx_valid_o}, 32'h0);
        push_byte(8'h41, 1'b1);
        check("push_latency", {31'h0, tx_valid_o}, 32'h1);
        check("head_a", {24'h0, tx_data_o}, 32'h41);
        push_byte(8'h42, 1'b1);
        push_byte(8'h43, 1'b1);
        rd_chk("status_3", A_ST, 32'h0000_0300);
        check("head_stable", {24'h0, tx_data_o}, 32'h41);
        tx_ready_i = 1'b1;
        idle(3);
        check("drained_valid", {31'h0, tx_valid_o}, 32'h0);
        check("drained_sb", exp_q.size(), 32'h0);
        rd_chk("status_empty", A_ST, 32'h0000_0002);

        // Overflow and sticky clear
        tx_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i), i < 8);
        rd_chk("status_ovf", A_ST, 32'h0000_0805);
        wr(A_ST, 32'h0000_0004);
        rd_chk("status_ovf_clr", A_ST, 32'h0000_0801);

        // Push into a full FIFO while popping
        tx_ready_i = 1'b1;
        push_byte(8'h39, 1'b1);
        tx_ready_i = 1'b0;
        rd_chk("status_full_pp", A_ST, 32'h0000_0801);

        // Reset with bytes queued
        tx_ready_i = 1'b1;
        idle(3);
        tx_ready_i = 1'b0;
        rd_chk("status_5", A_ST, 32'h0000_0500);
        wr(A_CY, 32'h0000_1234);
        tx_ready_i = 1'b1;
        do_reset();
        exp_q.delete();
        check("rst_mid_valid", {31'h0, tx_valid_o}, 32'h0);
        rd_chk("rst_mid_cycle", A_CY, 32'h0);
        rd_chk("rst_mid_status", A_ST, 32'h0000_0002);
        tx_ready_i = 1'b0;
`else
        // Console absent: TXDATA writes vanish, STATUS stays "empty"
        tx_ready_i = 1'b1;
        push_byte(8'h41, 1'b0);
        push_byte(8'h42, 1'b0);
        check("nocon_valid", {31'h0, tx_valid_o}, 32'h0);
        check("nocon_data", {24'h0, tx_data_o}, 32'h0);
        rd_chk("nocon_status", A_ST, 32'h0000_0002);
        wr(A_ST, 32'h0000_0004);
        rd_chk("nocon_status2", A_ST, 32'h0000_0002);
        wr(A_CY, 32'h0000_1234);
        do_reset();
        rd_chk("nocon_rst_cycle", A_CY, 32'h0);
        tx_ready_i = 1'b0;
`endif

        // RAM survives reset
        rd_chk("ram_after_rst", 32'h0000_0010, 32'hDEAD_BEEF);
        check("sb_final", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
